// File: rtl/ili9341_pkg.sv
// ---------------------------------------------------------------------------
// ili9341_pkg
// Shared definitions for the ILI9341 SPI responder:
//   - command codes for the column/page window and memory-write commands
//   - decoder FSM state encoding
//   - small helpers that map a command byte to its decoder state and build
//     a 9-bit panel coordinate from a big-endian 16-bit parameter pair
// ---------------------------------------------------------------------------
package ili9341_pkg;

    localparam logic [7:0] CMD_CASET = 8'h2A;  // column address set
    localparam logic [7:0] CMD_PASET = 8'h2B;  // page (row) address set
    localparam logic [7:0] CMD_RAMWR = 8'h2C;  // memory write

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CASET_P = 3'd1,
        ST_PASET_P = 3'd2,
        ST_RAMWR   = 3'd3,
        ST_SKIP    = 3'd4
    } dec_state_t;

    // Decoder state entered after a given command byte.
    function automatic dec_state_t cmd_state(input logic [7:0] code);
        dec_state_t st;
        case (code)
            CMD_CASET: st = ST_CASET_P;
            CMD_PASET: st = ST_PASET_P;
            CMD_RAMWR: st = ST_RAMWR;
            default:   st = ST_SKIP;
        endcase
        return st;
    endfunction

    // The panel is at most 320 pixels in either direction, so only the low
    // bit of the high parameter byte survives the truncation to 9 bits.
    function automatic logic [8:0] coord9(input logic msb, input logic [7:0] lsb);
        return {msb, lsb};
    endfunction

endpackage

// File: rtl/ili9341_spi_byte_rx.sv
// ---------------------------------------------------------------------------
// ili9341_spi_byte_rx
// Oversampled SPI mode-0 receiver. All SPI pins are brought into the clk
// domain through two flops; SCK rising edges are found on the synchronized
// level and MOSI is shifted in MSB first while CS is low.
//
// Ports:
//   clk, rst        system clock, asynchronous active-low reset
//   spi_sck/cs/mosi/dc  raw SPI pins (asynchronous to clk)
//   byte_valid      one-cycle strobe, a full byte was received
//   byte_data       the received byte (held until the next byte)
//   byte_dc         D/C level sampled with the 8th SCK rising edge
//   cs_idle         synchronized chip select, high while deselected
// ---------------------------------------------------------------------------
module ili9341_spi_byte_rx (
    input  logic       clk,
    input  logic       rst,
    input  logic       spi_sck,
    input  logic       spi_cs,
    input  logic       spi_mosi,
    input  logic       spi_dc,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       byte_dc,
    output logic       cs_idle
);

    logic       sck_p0, sck_p1, sck_p2;
    logic       cs_p0, cs_p1;
    logic       mosi_p0, mosi_p1;
    logic       dc_p0, dc_p1;
    logic [2:0] bit_cnt;
    logic [6:0] shift_reg;
    logic       sck_rise;

    // sck_p2 only serves as the previous synchronized level for edge detect;
    // mosi and dc share the same two-flop delay as sck, so the *_p1 values
    // line up with the detected edge.
    assign sck_rise = sck_p1 & ~sck_p2;
    assign cs_idle  = cs_p1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sck_p0     <= 1'b0;
            sck_p1     <= 1'b0;
            sck_p2     <= 1'b0;
            cs_p0      <= 1'b1;
            cs_p1      <= 1'b1;
            mosi_p0    <= 1'b0;
            mosi_p1    <= 1'b0;
            dc_p0      <= 1'b0;
            dc_p1      <= 1'b0;
            bit_cnt    <= 3'd0;
            shift_reg  <= 7'd0;
            byte_valid <= 1'b0;
            byte_data  <= 8'd0;
            byte_dc    <= 1'b0;
        end else begin
            // synchronizer stage p0 -> p1 -> p2
            sck_p0  <= spi_sck;
            sck_p1  <= sck_p0;
            sck_p2  <= sck_p1;
            cs_p0   <= spi_cs;
            cs_p1   <= cs_p0;
            mosi_p0 <= spi_mosi;
            mosi_p1 <= mosi_p0;
            dc_p0   <= spi_dc;
            dc_p1   <= dc_p0;

            // shift / byte assembly stage
            byte_valid <= 1'b0;
            if (cs_p1) begin
                // deselect throws away any partial byte
                bit_cnt <= 3'd0;
            end else if (sck_rise) begin
                shift_reg <= {shift_reg[5:0], mosi_p1};
                bit_cnt   <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    byte_valid <= 1'b1;
                    byte_data  <= {shift_reg, mosi_p1};
                    byte_dc    <= dc_p1;
                end
            end
        end
    end

endmodule

// File: rtl/ili9341_spi_responder.sv
// ---------------------------------------------------------------------------
// ili9341_spi_responder
// Behavioural ILI9341 panel front end. Bytes from the SPI receiver are
// decoded into commands; CASET/PASET set the drawing window and RAMWR
// streams RGB565 pixels which are reported together with their cursor
// position. The cursor walks the window row by row and wraps to its start.
//
// Parameters: H_RES, V_RES  panel size, sets the reset window.
// Ports:
//   clk, rst                 system clock, asynchronous active-low reset
//   spi_sck/cs/mosi/dc       SPI pins from the controller
//   byte_valid/data/dc       every received byte
//   cmd_valid, cmd_code      every command byte (dc = 0)
//   pix_valid, pix_x, pix_y, pix_data  every completed RAMWR pixel
// ---------------------------------------------------------------------------
import ili9341_pkg::*;

module ili9341_spi_responder #(
    parameter int H_RES = 240,
    parameter int V_RES = 320
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        spi_sck,
    input  logic        spi_cs,
    input  logic        spi_mosi,
    input  logic        spi_dc,
    output logic        byte_valid,
    output logic [7:0]  byte_data,
    output logic        byte_dc,
    output logic        cmd_valid,
    output logic [7:0]  cmd_code,
    output logic        pix_valid,
    output logic [8:0]  pix_x,
    output logic [8:0]  pix_y,
    output logic [15:0] pix_data
);

    localparam logic [8:0] X_END_RST = 9'(H_RES - 1);
    localparam logic [8:0] Y_END_RST = 9'(V_RES - 1);

    logic       cs_idle;

    dec_state_t state;
    logic [1:0] par_idx;
    logic       start_msb;
    logic [8:0] start_val;
    logic       end_msb;
    logic [8:0] x_start, x_end, y_start, y_end;
    logic [8:0] cur_x, cur_y;
    logic       hi_pending;
    logic [7:0] hi_byte;

    ili9341_spi_byte_rx u_byte_rx (
        .clk        (clk),
        .rst        (rst),
        .spi_sck    (spi_sck),
        .spi_cs     (spi_cs),
        .spi_mosi   (spi_mosi),
        .spi_dc     (spi_dc),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_dc    (byte_dc),
        .cs_idle    (cs_idle)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            par_idx    <= 2'd0;
            start_msb  <= 1'b0;
            start_val  <= 9'd0;
            end_msb    <= 1'b0;
            x_start    <= 9'd0;
            x_end      <= X_END_RST;
            y_start    <= 9'd0;
            y_end      <= Y_END_RST;
            cur_x      <= 9'd0;
            cur_y      <= 9'd0;
            hi_pending <= 1'b0;
            hi_byte    <= 8'd0;
            cmd_valid  <= 1'b0;
            cmd_code   <= 8'd0;
            pix_valid  <= 1'b0;
            pix_x      <= 9'd0;
            pix_y      <= 9'd0;
            pix_data   <= 16'd0;
        end else begin
            // decode stage: consumes the byte strobed by the receiver
            cmd_valid <= 1'b0;
            pix_valid <= 1'b0;

            if (byte_valid && !byte_dc) begin
                // a command always wins, whatever was in progress
                cmd_valid  <= 1'b1;
                cmd_code   <= byte_data;
                par_idx    <= 2'd0;
                hi_pending <= 1'b0;
                state      <= cmd_state(byte_data);
                if (byte_data == CMD_RAMWR) begin
                    cur_x <= x_start;
                    cur_y <= y_start;
                end
            end else if (byte_valid) begin
                case (state)
                    ST_CASET_P, ST_PASET_P: begin
                        par_idx <= par_idx + 2'd1;
                        case (par_idx)
                            2'd0: start_msb <= byte_data[0];
                            2'd1: start_val <= coord9(start_msb, byte_data);
                            2'd2: end_msb   <= byte_data[0];
                            2'd3: begin
                                // window only moves once all four bytes arrived
                                if (state == ST_CASET_P) begin
                                    x_start <= start_val;
                                    x_end   <= coord9(end_msb, byte_data);
                                end else begin
                                    y_start <= start_val;
                                    y_end   <= coord9(end_msb, byte_data);
                                end
                                state <= ST_IDLE;
                            end
                        endcase
                    end
                    ST_RAMWR: begin
                        if (!hi_pending) begin
                            hi_byte    <= byte_data;
                            hi_pending <= 1'b1;
                        end else begin
                            hi_pending <= 1'b0;
                            pix_valid  <= 1'b1;
                            pix_x      <= cur_x;
                            pix_y      <= cur_y;
                            pix_data   <= {hi_byte, byte_data};
                            if (cur_x == x_end) begin
                                cur_x <= x_start;
                                cur_y <= (cur_y == y_end) ? y_start : cur_y + 9'd1;
                            end else begin
                                cur_x <= cur_x + 9'd1;
                            end
                        end
                    end
                    default: ;
                endcase
            end else if (cs_idle) begin
                // deselect drops a half pixel but leaves the state alone
                hi_pending <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ili9341_spi_responder.sv
// ---------------------------------------------------------------------------
// tb_ili9341_spi_responder
// Self-checking bench: directed vector table, hand-written corner sequences
// and a randomized byte stream checked against a window/pixel-index model.
// ---------------------------------------------------------------------------
module tb_ili9341_spi_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        spi_sck, spi_cs, spi_mosi, spi_dc;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_dc;
    logic        cmd_valid;
    logic [7:0]  cmd_code;
    logic        pix_valid;
    logic [8:0]  pix_x, pix_y;
    logic [15:0] pix_data;

    always #5 clk = ~clk;

    ili9341_spi_responder #(.H_RES(240), .V_RES(320)) dut (
        .clk        (clk),
        .rst        (rst),
        .spi_sck    (spi_sck),
        .spi_cs     (spi_cs),
        .spi_mosi   (spi_mosi),
        .spi_dc     (spi_dc),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_dc    (byte_dc),
        .cmd_valid  (cmd_valid),
        .cmd_code   (cmd_code),
        .pix_valid  (pix_valid),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .pix_data   (pix_data)
    );

    // ---------------- strobe monitor ----------------
    int          nb = 0, nc = 0, np = 0;
    logic [7:0]  last_byte = 8'd0;
    logic        last_dc = 1'b0;
    logic [8:0]  last_x = 9'd0, last_y = 9'd0;
    logic [15:0] last_pix = 16'd0;

    always @(negedge clk) begin
        if (byte_valid) begin
            nb        <= nb + 1;
            last_byte <= byte_data;
            last_dc   <= byte_dc;
        end
        if (cmd_valid) nc <= nc + 1;
        if (pix_valid) begin
            np       <= np + 1;
            last_x   <= pix_x;
            last_y   <= pix_y;
            last_pix <= pix_data;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Pixel position derived from the pixel index inside the window.
    int m_mode;          // 0 ignore data, 1 column params, 2 row params, 3 pixels
    int m_idx, m_n, m_hi_have, m_hi;
    int m_par[4];
    int m_xs, m_xe, m_ys, m_ye;

    task automatic model_reset();
        m_mode = 0; m_idx = 0; m_n = 0; m_hi_have = 0; m_hi = 0;
        m_xs = 0; m_xe = 239; m_ys = 0; m_ye = 319;
    endtask

    task automatic model_byte(input logic dc, input logic [7:0] b, output logic e_pix,
                              output logic [8:0] ex, output logic [8:0] ey,
                              output logic [15:0] ep);
        int s, e, w, h;
        e_pix = 1'b0; ex = 9'd0; ey = 9'd0; ep = 16'd0;
        if (!dc) begin
            m_idx = 0; m_hi_have = 0; m_n = 0;
            m_mode = (b == 8'h2A) ? 1 : (b == 8'h2B) ? 2 : (b == 8'h2C) ? 3 : 0;
        end else if (m_mode == 1 || m_mode == 2) begin
            m_par[m_idx] = int'(b);
            m_idx++;
            if (m_idx == 4) begin
                s = (m_par[0] * 256 + m_par[1]) % 512;
                e = (m_par[2] * 256 + m_par[3]) % 512;
                if (m_mode == 1) begin m_xs = s; m_xe = e; end
                else             begin m_ys = s; m_ye = e; end
                m_mode = 0;
            end
        end else if (m_mode == 3) begin
            if (m_hi_have == 0) begin
                m_hi_have = 1; m_hi = int'(b);
            end else begin
                w = m_xe - m_xs + 1;
                h = m_ye - m_ys + 1;
                e_pix = 1'b1;
                ex = 9'(m_xs + m_n % w);
                ey = 9'(m_ys + (m_n / w) % h);
                ep = 16'(m_hi * 256 + int'(b));
                m_n++;
                m_hi_have = 0;
            end
        end
    endtask

    // ---------------- SPI driver ----------------
    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            spi_mosi = b[i];
            repeat (2) @(negedge clk);
            spi_sck = 1'b1;
            repeat (2) @(negedge clk);
            spi_sck = 1'b0;
        end
    endtask

    task automatic xfer(input logic dc, input logic [7:0] b, input logic e_pix,
                        input logic [8:0] ex, input logic [8:0] ey, input logic [15:0] ep);
        int b0, c0, p0;
        b0 = nb; c0 = nc; p0 = np;
        spi_dc = dc;
        send_bits(b, 8);
        repeat (4) @(negedge clk);
        chk("byte_count", nb - b0, 1);
        chk("byte_data", int'(last_byte), int'(b));
        chk("byte_dc", int'(last_dc), int'(dc));
        chk("cmd_count", nc - c0, dc ? 0 : 1);
        if (!dc) chk("cmd_code", int'(cmd_code), int'(b));
        chk("pix_count", np - p0, int'(e_pix));
        if (e_pix) begin
            chk("pix_x", int'(last_x), int'(ex));
            chk("pix_y", int'(last_y), int'(ey));
            chk("pix_data", int'(last_pix), int'(ep));
        end
    endtask

    // byte whose expectations come from the model
    task automatic mxfer(input logic dc, input logic [7:0] b);
        logic e_pix; logic [8:0] ex, ey; logic [15:0] ep;
        model_byte(dc, b, e_pix, ex, ey, ep);
        xfer(dc, b, e_pix, ex, ey, ep);
    endtask

    task automatic reset_dut();
        rst = 1'b0; spi_sck = 1'b0; spi_cs = 1'b1; spi_mosi = 1'b0; spi_dc = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        spi_cs = 1'b0;
        repeat (2) @(negedge clk);
        model_reset();
    endtask

    task automatic window(input logic [7:0] c, input logic [8:0] s, input logic [8:0] e);
        mxfer(1'b0, c);
        mxfer(1'b1, {7'd0, s[8]});
        mxfer(1'b1, s[7:0]);
        mxfer(1'b1, {7'd0, e[8]});
        mxfer(1'b1, e[7:0]);
    endtask

    task automatic run_random();
        int kind, n, b0;
        logic [8:0] s, e;
        logic [7:0] pb[4];
        logic [7:0] c;
        for (int it = 0; it < 80; it++) begin
            kind = int'($urandom_range(0, 5));
            case (kind)
                0, 1: begin
                    c = (kind == 0) ? 8'h2A : 8'h2B;
                    s = 9'($urandom_range(0, 511));
                    e = 9'($urandom_range(int'(s), 511));
                    pb[0] = {7'($urandom_range(0, 127)), s[8]};
                    pb[1] = s[7:0];
                    pb[2] = {7'($urandom_range(0, 127)), e[8]};
                    pb[3] = e[7:0];
                    n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : 4;
                    mxfer(1'b0, c);
                    for (int j = 0; j < n; j++) mxfer(1'b1, pb[j]);
                    if (n < 4) mxfer(1'b0, 8'($urandom_range(0, 255)));
                end
                2: begin
                    mxfer(1'b0, 8'h2C);
                    n = int'($urandom_range(1, 6));
                    for (int j = 0; j < n; j++) mxfer(1'b1, 8'($urandom_range(0, 255)));
                end
                3: begin
                    mxfer(1'b0, 8'($urandom_range(0, 255)));
                    mxfer(1'b1, 8'($urandom_range(0, 255)));
                    mxfer(1'b1, 8'($urandom_range(0, 255)));
                end
                4: begin
                    b0 = nb;
                    spi_dc = 1'($urandom_range(0, 1));
                    send_bits(8'($urandom_range(0, 255)), int'($urandom_range(0, 7)));
                    spi_cs = 1'b1;
                    repeat (4) @(negedge clk);
                    spi_cs = 1'b0;
                    repeat (2) @(negedge clk);
                    chk("rand_partial_byte", nb - b0, 0);
                    m_hi_have = 0;
                end
                default: mxfer(1'b1, 8'($urandom_range(0, 255)));
            endcase
        end
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic        dc;
        logic [7:0]  b;
        logic        e_pix;
        logic [8:0]  ex;
        logic [8:0]  ey;
        logic [15:0] ep;
    } vec_t;

    vec_t tbl[18];

    initial begin
        int b0;

        tbl[0]  = '{1'b1, 8'hA5, 1'b0, 9'd0,  9'd0,  16'h0000};
        tbl[1]  = '{1'b0, 8'h2A, 1'b0, 9'd0,  9'd0,  16'h0000};
        tbl[2]  = '{1'b1, 8'h00, 1'b0, 9'd0,  9'd0,  16'h0000};
        tbl[3]  = '{1'b1, 8'h0A, 1'b0, 9'd0,  9'd0,  16'h0000};
        tbl[4]  = '{1'b1, 8'h00, 1'b0, 9'd0,  9'd0,  16'h0000};
        tbl[5]  = '{1'b1, 8'h0B, 1'b0, 9'd0,  9'd0,  16'h0000};
        tbl[6]  = '{1'b0, 8'h2B, 1'b0, 9'd0,  9'd0,  16'h0000};
        tbl[7]  = '{1'b1, 8'h00, 1'b0, 9'd0,  9'd0,  16'h0000};
        tbl[8]  = '{1'b1, 8'h14, 1'b0, 9'd0,  9'd0,  16'h0000};
        tbl[9]  = '{1'b1, 8'h00, 1'b0, 9'd0,  9'd0,  16'h0000};
        tbl[10] = '{1'b1, 8'h14, 1'b0, 9'd0,  9'd0,  16'h0000};
        tbl[11] = '{1'b0, 8'h2C, 1'b0, 9'd0,  9'd0,  16'h0000};
        tbl[12] = '{1'b1, 8'hF8, 1'b0, 9'd0,  9'd0,  16'h0000};
        tbl[13] = '{1'b1, 8'h00, 1'b1, 9'd10, 9'd20, 16'hF800};
        tbl[14] = '{1'b1, 8'h07, 1'b0, 9'd0,  9'd0,  16'h0000};
        tbl[15] = '{1'b1, 8'hE0, 1'b1, 9'd11, 9'd20, 16'h07E0};
        tbl[16] = '{1'b1, 8'hFF, 1'b0, 9'd0,  9'd0,  16'h0000};
        tbl[17] = '{1'b1, 8'hFF, 1'b1, 9'd10, 9'd20, 16'hFFFF};

        // outputs while held in reset
        rst = 1'b0; spi_sck = 1'b0; spi_cs = 1'b1; spi_mosi = 1'b0; spi_dc = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_byte_valid", int'(byte_valid), 0);
        chk("rst_byte_data", int'(byte_data), 0);
        chk("rst_byte_dc", int'(byte_dc), 0);
        chk("rst_cmd_valid", int'(cmd_valid), 0);
        chk("rst_cmd_code", int'(cmd_code), 0);
        chk("rst_pix_valid", int'(pix_valid), 0);
        chk("rst_pix_x", int'(pix_x), 0);
        chk("rst_pix_y", int'(pix_y), 0);
        chk("rst_pix_data", int'(pix_data), 0);
        reset_dut();

        // lone data byte, window setup and three pixels
        for (int i = 0; i < 18; i++)
            xfer(tbl[i].dc, tbl[i].b, tbl[i].e_pix, tbl[i].ex, tbl[i].ey, tbl[i].ep);

        // partial byte killed by deselect, then a full byte
        b0 = nb;
        spi_dc = 1'b1;
        send_bits(8'hFF, 5);
        spi_cs = 1'b1;
        repeat (4) @(negedge clk);
        spi_cs = 1'b0;
        repeat (2) @(negedge clk);
        chk("partial_no_byte", nb - b0, 0);
        xfer(1'b1, 8'h3C, 1'b0, 9'd0, 9'd0, 16'h0);

        // aborted CASET keeps the reset window
        reset_dut();
        xfer(1'b0, 8'h2A, 1'b0, 9'd0, 9'd0, 16'h0);
        xfer(1'b1, 8'h00, 1'b0, 9'd0, 9'd0, 16'h0);
        xfer(1'b1, 8'h05, 1'b0, 9'd0, 9'd0, 16'h0);
        xfer(1'b0, 8'h2C, 1'b0, 9'd0, 9'd0, 16'h0);
        xfer(1'b1, 8'h12, 1'b0, 9'd0, 9'd0, 16'h0);
        xfer(1'b1, 8'h34, 1'b1, 9'd0, 9'd0, 16'h1234);

        // reset in the middle of a pixel and of a byte
        reset_dut();
        window(8'h2A, 9'd5, 9'd6);
        xfer(1'b0, 8'h2C, 1'b0, 9'd0, 9'd0, 16'h0);
        xfer(1'b1, 8'h11, 1'b0, 9'd0, 9'd0, 16'h0);
        xfer(1'b1, 8'h22, 1'b1, 9'd5, 9'd0, 16'h1122);
        xfer(1'b1, 8'hAB, 1'b0, 9'd0, 9'd0, 16'h0);
        spi_dc = 1'b1;
        send_bits(8'hFF, 3);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("midrst_pix_x", int'(pix_x), 0);
        chk("midrst_pix_data", int'(pix_data), 0);
        chk("midrst_cmd_code", int'(cmd_code), 0);
        reset_dut();
        xfer(1'b0, 8'h2C, 1'b0, 9'd0, 9'd0, 16'h0);
        xfer(1'b1, 8'h12, 1'b0, 9'd0, 9'd0, 16'h0);
        xfer(1'b1, 8'h34, 1'b1, 9'd0, 9'd0, 16'h1234);

        // full-width row with the reset x end: 239 then wrap to next row
        reset_dut();
        mxfer(1'b0, 8'h2C);
        for (int i = 0; i <= 240; i++) begin
            mxfer(1'b1, 8'(i >> 8));
            mxfer(1'b1, 8'(i & 255));
            if (i == 239) begin
                chk("row_end_x", int'(last_x), 239);
                chk("row_end_y", int'(last_y), 0);
            end
        end
        chk("row_wrap_x", int'(last_x), 0);
        chk("row_wrap_y", int'(last_y), 1);

        // full-height column with the reset y end: 319 then wrap to y start
        reset_dut();
        window(8'h2A, 9'd239, 9'd239);
        mxfer(1'b0, 8'h2C);
        for (int i = 0; i <= 320; i++) begin
            mxfer(1'b1, 8'(i >> 8));
            mxfer(1'b1, 8'(i & 255));
            if (i == 319) begin
                chk("col_end_x", int'(last_x), 239);
                chk("col_end_y", int'(last_y), 319);
            end
        end
        chk("col_wrap_x", int'(last_x), 239);
        chk("col_wrap_y", int'(last_y), 0);

        // bottom-right 2x2 window wraps back to its own start
        window(8'h2A, 9'd238, 9'd239);
        window(8'h2B, 9'd318, 9'd319);
        mxfer(1'b0, 8'h2C);
        for (int i = 0; i < 5; i++) begin
            mxfer(1'b1, 8'hC0);
            mxfer(1'b1, 8'(i));
        end
        chk("corner_wrap_x", int'(last_x), 238);
        chk("corner_wrap_y", int'(last_y), 318);

        // randomized stream against the model
        reset_dut();
        run_random();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ili9341_spi_responder.md
ILI9341_SPI_RESPONDER -- requirements
Module: ili9341_spi_responder

Interface
REQ-001 Parameter H_RES, default 240, horizontal pixel count of the panel model.
REQ-002 Parameter V_RES, default 320, vertical pixel count of the panel model.
REQ-003 clk  input  1  system clock; the only clock; SHALL be at least 4x the SPI SCK frequency.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 spi_sck  input  1  SPI clock from the controller, asynchronous to clk; idle low (mode 0).
REQ-006 spi_cs  input  1  chip select, active low.
REQ-007 spi_mosi  input  1  serial data, MSB first.
REQ-008 spi_dc  input  1  0 = command byte, 1 = data byte.
REQ-009 byte_valid  output  1  one-cycle strobe: a complete byte was received.
REQ-010 byte_data  output  8  received byte; valid with byte_valid.
REQ-011 byte_dc  output  1  spi_dc value sampled on the 8th SCK rising edge.
REQ-012 cmd_valid  output  1  one-cycle strobe: a command byte was decoded.
REQ-013 cmd_code  output  8  last command byte.
REQ-014 pix_valid  output  1  one-cycle strobe: a full RGB565 pixel was written.
REQ-015 pix_x  output  9  column of the written pixel.
REQ-016 pix_y  output  9  row of the written pixel.
REQ-017 pix_data  output  16  RGB565 pixel, first byte in bits 15:8.

Function
REQ-018 spi_sck, spi_cs, spi_mosi and spi_dc SHALL pass through a 2-flop synchronizer; a SCK rising edge SHALL be detected from the synchronized level.
REQ-019 On each detected SCK rising edge with spi_cs low, the block SHALL shift spi_mosi into an 8-bit register, MSB first.
REQ-020 On the 8th bit, byte_valid SHALL pulse for exactly one cycle, 1 cycle after edge detection, with byte_data and byte_dc stable.
REQ-021 spi_cs going high SHALL clear the bit counter; a partial byte SHALL be discarded without byte_valid.
REQ-022 Decoder FSM states: IDLE, CASET_P, PASET_P, RAMWR, SKIP.
REQ-023 A byte with dc=0 SHALL, from any state, pulse cmd_valid, load cmd_code, reset the parameter index and go to CASET_P (0x2A), PASET_P (0x2B), RAMWR (0x2C, also loading cursor x=x_start, y=y_start), or SKIP (any other code).
REQ-024 CASET_P SHALL take 4 data bytes as x_start[15:8], x_start[7:0], x_end[15:8], x_end[7:0], truncated to 9 bits, then go to IDLE; PASET_P identically for y_start/y_end.
REQ-025 Window registers SHALL update only when all 4 parameters are received; an aborting command byte SHALL leave them unchanged.
REQ-026 RAMWR SHALL pair data bytes high-then-low; on each low byte pix_valid SHALL pulse with the current cursor and the 16-bit pixel.
REQ-027 After each pixel: if x == x_end then x := x_start and y advances, else x increments; if y == y_end on that wrap then y := y_start.
REQ-028 A dangling high byte at RAMWR end (command byte or cs high) SHALL be dropped.
REQ-029 Data bytes in IDLE or SKIP SHALL produce only byte_valid.
REQ-030 Window reset defaults: x_start=0, x_end=H_RES-1, y_start=0, y_end=V_RES-1.
REQ-031 cs going high SHALL NOT change the FSM state except as in REQ-028.

Reset
REQ-032 While rst is low: all strobes 0, byte_data/byte_dc/cmd_code/pix_x/pix_y/pix_data 0, bit counter 0, FSM IDLE, synchronizers set to sck=0, cs=1, mosi=0, dc=0, window per REQ-030.
REQ-033 Reset asserted mid-byte or mid-pixel SHALL discard all partial state; reception restarts cleanly after release.

Structure
REQ-034 Command codes (0x2A, 0x2B, 0x2C) and the FSM state encoding SHALL live in a shared package ili9341_pkg.
REQ-035 Serial-to-byte logic (REQ-018..021) SHALL be a sub-module ili9341_spi_byte_rx; decoder and cursor in the top.

Verification
REQ-036 Byte 0xA5 with dc=1 -> one byte_valid, byte_data=0xA5, byte_dc=1, no cmd_valid.
REQ-037 Command 0x2A, data 00 0A 00 0B; 0x2B, data 00 14 00 14; 0x2C, data F8 00 07 E0 FF FF -> pix (10,20,F800), (11,20,07E0), (10,20,FFFF).
REQ-038 cs high after 5 bits, then full byte 0x3C -> only one byte_valid, data 0x3C.
REQ-039 0x2A with only 2 data bytes then 0x2C and 2 data bytes -> pix_x=0, pix_y=0 (window unchanged).
REQ-040 rst low during RAMWR after a high byte, release, 0x2C, 12 34 -> pix (0,0,1234).
REQ-041 Full 240x320 RAMWR from reset -> last pixel at (239,319), next pixel at (0,0).
